// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg_pkg
// Brief   : Shared BCD types and limits for the cascaded segment counter.
// Rev     : 1.0
// ============================================================================
package seg_pkg;

    typedef logic [3:0] bcd_t;

    localparam int BCD_MAX    = 9;
    localparam int DIGITS_MIN = 1;
    localparam int DIGITS_MAX = 8;

    function automatic logic bcd_in_range(input bcd_t value, input int unsigned limit);
        return value <= bcd_t'(limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_bcd_digit.sv
`default_nettype none
// ============================================================================
// Module  : seg_bcd_digit
// Brief   : One up/down BCD digit register with terminal-value flag.
// Rev     : 1.0
// ============================================================================
module seg_bcd_digit
    import seg_pkg::*;
#(
    parameter int MAX = BCD_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic up_dn,
    input  logic clr,
    input  logic load,
    input  logic load_ok,
    input  bcd_t load_val,
    output bcd_t digit,
    output logic term
);

    localparam bcd_t c_MAX = bcd_t'(MAX);

    bcd_t r_digit;
    bcd_t w_next;

    assign term  = up_dn ? (r_digit == c_MAX) : (r_digit == '0);
    assign digit = r_digit;

    // A rejected load still blocks the count step for this edge.
    always_comb begin
        w_next = r_digit;
        if (clr) begin
            w_next = '0;
        end else if (load) begin
            if (load_ok) begin
                w_next = load_val;
            end
        end else if (en) begin
            if (up_dn) begin
                w_next = term ? '0 : r_digit + 4'd1;
            end else begin
                w_next = term ? c_MAX : r_digit - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit <= '0;
        end else begin
            r_digit <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_cnt_chain.sv
`default_nettype none
// ============================================================================
// Module  : seg_cnt_chain
// Brief   : Cascaded BCD up/down counter with validated load and sticky wrap.
// Rev     : 1.0
// ============================================================================
module seg_cnt_chain
    import seg_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int TOP_MAX = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up_dn,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                ovf_clr,
    output logic [4*DIGITS-1:0] digits,
    output logic                carry_out,
    output logic [DIGITS-1:0]   dig_en,
    output logic                zero,
    output logic                ovf,
    output logic                load_err
);

    logic [DIGITS-1:0] w_term;
    logic [DIGITS-1:0] w_dig_en;
    logic              w_load_ok;
    logic              r_ovf;
    logic              r_load_err;

    always_comb begin
        w_load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_in_range(load_val[4*i +: 4],
                              (i == DIGITS - 1) ? TOP_MAX : BCD_MAX)) begin
                w_load_ok = 1'b0;
            end
        end
    end

    // Ripple enable: a digit steps only when every lower digit is terminal.
    always_comb begin
        w_dig_en    = '0;
        w_dig_en[0] = en;
        for (int i = 1; i < DIGITS; i++) begin
            w_dig_en[i] = w_dig_en[i-1] & w_term[i-1];
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            seg_bcd_digit #(
                .MAX ((gi == DIGITS - 1) ? TOP_MAX : BCD_MAX)
            ) u_digit (
                .clk      (clk),
                .reset    (reset),
                .en       (w_dig_en[gi]),
                .up_dn    (up_dn),
                .clr      (clr),
                .load     (load),
                .load_ok  (w_load_ok),
                .load_val (load_val[4*gi +: 4]),
                .digit    (digits[4*gi +: 4]),
                .term     (w_term[gi])
            );
        end
    endgenerate

    assign dig_en    = w_dig_en;
    assign carry_out = w_dig_en[DIGITS-1] & w_term[DIGITS-1];
    assign zero      = (digits == '0);

    // Set beats clear so a wrap coinciding with ovf_clr is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf      <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            if (carry_out) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
            r_load_err <= load & ~clr & ~w_load_ok;
        end
    end

    assign ovf      = r_ovf;
    assign load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_seg_cnt_chain.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_cnt_chain
// Brief   : Self-checking bench for seg_cnt_chain against an arithmetic model.
// Rev     : 1.0
// ============================================================================
module tb_seg_cnt_chain;

    localparam int A_D  = 4;
    localparam int A_TM = 9;
    localparam int B_D  = 2;
    localparam int B_TM = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_en, a_up, a_clr, a_load, a_oc;
    logic [15:0] a_lv, a_digits;
    logic [3:0]  a_dig_en;
    logic        a_carry, a_zero, a_ovf, a_lerr;

    logic        b_reset, b_en, b_up, b_clr, b_load, b_oc;
    logic [7:0]  b_lv, b_digits;
    logic [1:0]  b_dig_en;
    logic        b_carry, b_zero, b_ovf, b_lerr;

    int a_val, b_val;
    bit a_ovf_m, a_lerr_m, b_ovf_m, b_lerr_m;
    int n_total = 0;
    int n_pass  = 0;
    int b_wraps = 0;

    seg_cnt_chain #(.DIGITS(A_D), .TOP_MAX(A_TM)) u_dut_a (
        .clk(clk), .reset(a_reset), .en(a_en), .up_dn(a_up), .clr(a_clr),
        .load(a_load), .load_val(a_lv), .ovf_clr(a_oc), .digits(a_digits),
        .carry_out(a_carry), .dig_en(a_dig_en), .zero(a_zero), .ovf(a_ovf),
        .load_err(a_lerr)
    );

    seg_cnt_chain #(.DIGITS(B_D), .TOP_MAX(B_TM)) u_dut_b (
        .clk(clk), .reset(b_reset), .en(b_en), .up_dn(b_up), .clr(b_clr),
        .load(b_load), .load_val(b_lv), .ovf_clr(b_oc), .digits(b_digits),
        .carry_out(b_carry), .dig_en(b_dig_en), .zero(b_zero), .ovf(b_ovf),
        .load_err(b_lerr)
    );

    // The count is modelled as a plain integer in a mixed-radix ring.
    function automatic int pow10(input int i);
        int r = 1;
        for (int k = 0; k < i; k++) r = r * 10;
        return r;
    endfunction

    function automatic int modulus(input int d, input int tm);
        return (tm + 1) * pow10(d - 1);
    endfunction

    function automatic int bcd2int(input logic [31:0] v, input int d);
        int r = 0;
        for (int k = 0; k < d; k++) r = r + int'(v[4*k +: 4]) * pow10(k);
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(input int x, input int d);
        logic [31:0] r = '0;
        for (int k = 0; k < d; k++) r[4*k +: 4] = 4'((x / pow10(k)) % 10);
        return r;
    endfunction

    function automatic bit load_ok(input logic [31:0] v, input int d, input int tm);
        for (int k = 0; k < d; k++) begin
            if (int'(v[4*k +: 4]) > ((k == d - 1) ? tm : 9)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] dig_en_of(input int val, input bit en, input bit up, input int d);
        logic [31:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r[i] = en && (up ? (val % pow10(i) == pow10(i) - 1) : (val % pow10(i) == 0));
        end
        return r;
    endfunction

    function automatic bit carry_of(input int val, input bit en, input bit up, input int d, input int tm);
        return en && (up ? (val == modulus(d, tm) - 1) : (val == 0));
    endfunction

    task automatic model_next(input int d, input int tm, input int val, input bit ovf,
                              input bit rst, input bit en, input bit up, input bit clr,
                              input bit ld, input logic [31:0] lv, input bit oc,
                              output int nval, output bit novf, output bit nlerr);
        int  m  = modulus(d, tm);
        bit  ok = load_ok(lv, d, tm);
        bit  cy = carry_of(val, en, up, d, tm);
        if (rst) begin
            nval = 0; novf = 1'b0; nlerr = 1'b0;
        end else begin
            novf  = cy ? 1'b1 : (oc ? 1'b0 : ovf);
            nlerr = !clr && ld && !ok;
            if (clr)     nval = 0;
            else if (ld) nval = ok ? bcd2int(lv, d) : val;
            else if (en) nval = up ? (val + 1) % m : (val + m - 1) % m;
            else         nval = val;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_a(input bit rst, input bit en, input bit up, input bit clr,
                         input bit ld, input logic [15:0] lv, input bit oc);
        int nv; bit no; bit nl;
        a_reset = rst; a_en = en; a_up = up; a_clr = clr; a_load = ld; a_lv = lv; a_oc = oc;
        #1;
        check("a_dig_en", 32'(a_dig_en), dig_en_of(a_val, en, up, A_D));
        check("a_carry",  32'(a_carry),  32'(carry_of(a_val, en, up, A_D, A_TM)));
        check("a_zero",   32'(a_zero),   32'(a_val == 0));
        model_next(A_D, A_TM, a_val, a_ovf_m, rst, en, up, clr, ld, 32'(lv), oc, nv, no, nl);
        @(posedge clk);
        a_val = nv; a_ovf_m = no; a_lerr_m = nl;
        #1;
        check("a_digits",   32'(a_digits), int2bcd(a_val, A_D));
        check("a_ovf",      32'(a_ovf),    32'(a_ovf_m));
        check("a_load_err", 32'(a_lerr),   32'(a_lerr_m));
    endtask

    task automatic cyc_b(input bit en, input bit up);
        int nv; bit no; bit nl;
        b_en = en; b_up = up;
        #1;
        check("b_dig_en", 32'(b_dig_en), dig_en_of(b_val, en, up, B_D));
        check("b_carry",  32'(b_carry),  32'(carry_of(b_val, en, up, B_D, B_TM)));
        if (b_carry) b_wraps++;
        model_next(B_D, B_TM, b_val, b_ovf_m, 1'b0, en, up, 1'b0, 1'b0, 32'(b_lv), 1'b0, nv, no, nl);
        @(posedge clk);
        b_val = nv; b_ovf_m = no; b_lerr_m = nl;
        #1;
        check("b_digits", 32'(b_digits), int2bcd(b_val, B_D));
        check("b_ovf",    32'(b_ovf),    32'(b_ovf_m));
    endtask

    initial begin
        bit          r_rst, r_en, r_up, r_clr, r_ld, r_oc;
        logic [15:0] r_lv;

        a_reset = 1'b1; a_en = 1'b1; a_up = 1'b1; a_clr = 1'b0; a_load = 1'b0; a_lv = '0; a_oc = 1'b0;
        b_reset = 1'b1; b_en = 1'b0; b_up = 1'b1; b_clr = 1'b0; b_load = 1'b0; b_lv = '0; b_oc = 1'b0;
        a_val = 0; a_ovf_m = 1'b0; a_lerr_m = 1'b0;
        b_val = 0; b_ovf_m = 1'b0; b_lerr_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_digits", 32'(a_digits), 32'h0);
        check("reset_ovf",    32'(a_ovf),    32'h0);
        check("reset_lerr",   32'(a_lerr),   32'h0);
        check("reset_zero",   32'(a_zero),   32'h1);
        a_reset = 1'b0; a_en = 1'b0;
        b_reset = 1'b0;

        // Two-digit chain with a 5 top: 60 steps is one full revolution.
        for (int k = 0; k < 60; k++) cyc_b(1'b1, 1'b1);
        check("b_full_turn", 32'(b_digits), 32'h00);
        check("b_one_wrap",  32'(b_wraps),  32'd1);
        cyc_b(1'b0, 1'b1);

        // Load 9998 then count through the wrap.
        cyc_a(0, 0, 1, 0, 1, 16'h9998, 0);
        cyc_a(0, 1, 1, 0, 0, 16'h0000, 0);
        check("wrap_9999", 32'(a_digits), 32'h9999);
        cyc_a(0, 1, 1, 0, 0, 16'h0000, 0);
        check("wrap_0000", 32'(a_digits), 32'h0000);
        check("wrap_ovf",  32'(a_ovf),    32'h1);
        cyc_a(0, 1, 1, 0, 0, 16'h0000, 0);
        check("wrap_0001", 32'(a_digits), 32'h0001);

        // Down count across digit borrows and through zero.
        cyc_a(0, 0, 1, 0, 1, 16'h0100, 0);
        cyc_a(0, 1, 0, 0, 0, 16'h0000, 0);
        check("down_0099", 32'(a_digits), 32'h0099);
        cyc_a(0, 0, 1, 0, 1, 16'h0000, 0);
        cyc_a(0, 1, 0, 0, 0, 16'h0000, 0);
        check("down_9999", 32'(a_digits), 32'h9999);

        // Out-of-range load is rejected and blocks counting.
        cyc_a(0, 1, 1, 0, 1, 16'h12A4, 0);
        check("bad_load_hold", 32'(a_digits), 32'h9999);
        check("bad_load_err",  32'(a_lerr),   32'h1);
        cyc_a(0, 0, 1, 0, 0, 16'h0000, 0);
        check("bad_load_pulse", 32'(a_lerr), 32'h0);

        // clr beats load and count; wrap beats ovf_clr.
        cyc_a(0, 1, 1, 1, 1, 16'h5555, 0);
        check("clr_wins", 32'(a_digits), 32'h0000);
        cyc_a(0, 0, 1, 0, 0, 16'h0000, 1);
        check("ovf_cleared", 32'(a_ovf), 32'h0);
        cyc_a(0, 0, 1, 0, 1, 16'h9999, 0);
        cyc_a(0, 1, 1, 0, 0, 16'h0000, 1);
        check("set_beats_clr", 32'(a_ovf), 32'h1);

        // Reset mid-count discards pending ovf and load error.
        cyc_a(0, 0, 1, 0, 1, 16'h0455, 0);
        cyc_a(0, 1, 1, 0, 0, 16'h0000, 0);
        cyc_a(0, 1, 1, 0, 0, 16'h0000, 0);
        check("pre_reset_0457", 32'(a_digits), 32'h0457);
        check("pre_reset_ovf",  32'(a_ovf),    32'h1);
        cyc_a(1, 1, 1, 0, 1, 16'hFFFF, 0);
        check("mid_reset_digits", 32'(a_digits), 32'h0000);
        check("mid_reset_ovf",    32'(a_ovf),    32'h0);
        check("mid_reset_lerr",   32'(a_lerr),   32'h0);

        for (int k = 0; k < 400; k++) begin
            r_rst = ($urandom_range(0, 59) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_up  = 1'($urandom_range(0, 1));
            r_clr = ($urandom_range(0, 19) == 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_oc  = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       r_lv = 16'($urandom);
                1:       r_lv = 16'(int2bcd(9995 + $urandom_range(0, 4), A_D));
                2:       r_lv = 16'(int2bcd($urandom_range(0, 4), A_D));
                default: r_lv = 16'(int2bcd($urandom_range(0, 9999), A_D));
            endcase
            cyc_a(r_rst, r_en, r_up, r_clr, r_ld, r_lv, r_oc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
